// File: rtl/msg_frame_scheduler_pkg.sv
// rtl/msg_frame_scheduler_pkg.sv - shared types and sizing helpers for the message frame scheduler
package msg_frame_scheduler_pkg;

  localparam int MSG_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // One extra bit over the address so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/msg_frame_scheduler_if.sv
// rtl/msg_frame_scheduler_if.sv - host/transmit-side signal bundle of the message frame scheduler
interface msg_frame_scheduler_if
  import msg_frame_scheduler_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int MSG_BITS = MSG_W
) ();

  logic                     enable;
  logic                     wr_en;
  logic [MSG_BITS-1:0]      wr_data;
  logic                     ovf_clr;
  logic                     bit_tick;
  logic                     full;
  logic                     empty;
  logic [ptr_w(DEPTH)-1:0]  level;
  logic                     overflow;
  logic                     send;
  logic [MSG_BITS-1:0]      Msg;
  logic                     busy;

  modport master (
    output enable, wr_en, wr_data, ovf_clr, bit_tick,
    input  full, empty, level, overflow, send, Msg, busy
  );

  modport slave (
    input  enable, wr_en, wr_data, ovf_clr, bit_tick,
    output full, empty, level, overflow, send, Msg, busy
  );

endinterface

// File: rtl/msg_fifo.sv
// rtl/msg_fifo.sv - synchronous message FIFO with registered full/empty/level and sticky overflow
module msg_fifo
  import msg_frame_scheduler_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = MSG_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_wr_en,
  input  logic [WIDTH-1:0]        i_wr_data,
  input  logic                    i_rd_en,
  input  logic                    i_ovf_clr,
  output logic [WIDTH-1:0]        o_rd_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [ptr_w(DEPTH)-1:0] o_level,
  output logic                    o_overflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_level;
  logic             r_full;
  logic             r_empty;
  logic             r_overflow;

  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_wr_nxt;
  logic [PW-1:0]    w_rd_nxt;

  // Gated on the registered flags, so a write while full drops even if a pop lands in the same cycle.
  assign w_push   = i_wr_en && !r_full;
  assign w_pop    = i_rd_en && !r_empty;
  assign w_wr_nxt = r_wr_ptr + {{AW{1'b0}}, w_push};
  assign w_rd_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_level  <= w_wr_nxt - w_rd_nxt;
      r_full   <= (w_wr_nxt[AW] != w_rd_nxt[AW]) && (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
      r_empty  <= (w_wr_nxt == w_rd_nxt);
      if (i_wr_en && r_full) begin
        r_overflow <= 1'b1;
      end else if (i_ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  assign o_rd_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_level    = r_level;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/msg_frame_scheduler.sv
// rtl/msg_frame_scheduler.sv - queues host messages and presents each on Msg for one full frame of bit ticks
module msg_frame_scheduler
  import msg_frame_scheduler_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int MSG_BITS   = MSG_W,
  parameter int GUARD_BITS = 2
) (
  input logic                  clk,
  input logic                  rst,
  msg_frame_scheduler_if.slave bus
);

  localparam int PW    = ptr_w(DEPTH);
  localparam int FRAME = MSG_BITS + GUARD_BITS;
  localparam int CW    = $clog2(FRAME + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_send;
  logic                r_busy;
  logic [CW-1:0]       r_cnt;
  logic [MSG_BITS-1:0] r_msg;

  logic                w_send_nxt;
  logic                w_busy_nxt;
  logic [CW-1:0]       w_cnt_nxt;
  logic                w_load;
  logic                w_pop;
  logic                w_start;
  logic                w_frame_last;

  logic [MSG_BITS-1:0] w_head;
  logic                w_full;
  logic                w_empty;
  logic [PW-1:0]       w_level;
  logic                w_overflow;

  msg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (MSG_BITS)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .i_wr_en    (bus.wr_en),
    .i_wr_data  (bus.wr_data),
    .i_rd_en    (w_pop),
    .i_ovf_clr  (bus.ovf_clr),
    .o_rd_data  (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_level    (w_level),
    .o_overflow (w_overflow)
  );

  assign w_start      = bus.enable && !w_empty;
  assign w_frame_last = (r_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_SEND;
      ST_SEND: if (bus.bit_tick) w_state_nxt = ST_HOLD;
      ST_HOLD: if (bus.bit_tick && w_frame_last) w_state_nxt = w_start ? ST_SEND : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The tick that releases send is bit 0 of the frame, so the counter restarts at 1 in HOLD.
  always_comb begin
    w_pop      = 1'b0;
    w_load     = 1'b0;
    w_send_nxt = r_send;
    w_busy_nxt = r_busy;
    w_cnt_nxt  = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_pop      = 1'b1;
          w_load     = 1'b1;
          w_send_nxt = 1'b1;
          w_busy_nxt = 1'b1;
          w_cnt_nxt  = '0;
        end
      end
      ST_SEND: begin
        if (bus.bit_tick) begin
          w_send_nxt = 1'b0;
          w_cnt_nxt  = CW'(1);
        end
      end
      ST_HOLD: begin
        if (bus.bit_tick) begin
          if (w_frame_last) begin
            w_cnt_nxt = '0;
            if (w_start) begin
              w_pop      = 1'b1;
              w_load     = 1'b1;
              w_send_nxt = 1'b1;
            end else begin
              w_busy_nxt = 1'b0;
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_send_nxt = 1'b0;
        w_busy_nxt = 1'b0;
        w_cnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_send <= 1'b0;
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_msg  <= '0;
    end else begin
      r_send <= w_send_nxt;
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
      if (w_load) begin
        r_msg <= w_head;
      end
    end
  end

  assign bus.send     = r_send;
  assign bus.busy     = r_busy;
  assign bus.Msg      = r_msg;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.level    = w_level;
  assign bus.overflow = w_overflow;

endmodule

// File: tb/tb_msg_frame_scheduler.sv
// tb/tb_msg_frame_scheduler.sv - self-checking bench for msg_frame_scheduler
module tb_msg_frame_scheduler;
  import msg_frame_scheduler_pkg::*;

  localparam int DEPTH = 8;
  localparam int MB    = 5;
  localparam int GB    = 2;
  localparam int LW    = ptr_w(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  msg_frame_scheduler_if #(.DEPTH(DEPTH), .MSG_BITS(MB)) bus ();

  msg_frame_scheduler #(
    .DEPTH      (DEPTH),
    .MSG_BITS   (MB),
    .GUARD_BITS (GB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [MB-1:0] sb[$];

  typedef struct {
    logic          wr_en;
    logic [MB-1:0] data;
    logic          clr;
    logic          exp_full;
    logic [LW-1:0] exp_level;
    logic          exp_ovf;
  } vec_t;

  vec_t vt[13];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_msg(input logic [MB-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    sb.push_back(d);
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_tick();
    repeat (15) step();
    bus.bit_tick = 1'b1;
    step();
    bus.bit_tick = 1'b0;
  endtask

  // Scoreboard side: every frame start must present the next accepted message, held while busy.
  logic          send_q = 1'b0;
  logic          busy_q = 1'b0;
  logic [MB-1:0] msg_q  = '0;
  logic [MB-1:0] mon_exp;

  always @(negedge clk) begin
    if (!rst) begin
      send_q = 1'b0;
      busy_q = 1'b0;
      msg_q  = '0;
    end else begin
      if (bus.send && !send_q) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          mon_exp = sb.pop_front();
          chk("frame_msg", bus.Msg, mon_exp);
        end
      end else if (bus.busy && busy_q) begin
        chk("msg_stable", bus.Msg, msg_q);
      end
      send_q = bus.send;
      busy_q = bus.busy;
      msg_q  = bus.Msg;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic prev_full;
    logic [MB-1:0] exp_m;

    bus.enable   = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_data  = '0;
    bus.ovf_clr  = 1'b0;
    bus.bit_tick = 1'b0;

    // Reset held with random inputs.
    repeat (6) begin
      bus.enable   = 1'($urandom);
      bus.wr_en    = 1'($urandom);
      bus.wr_data  = MB'($urandom);
      bus.ovf_clr  = 1'($urandom);
      bus.bit_tick = 1'($urandom);
      step();
      chk("rst_empty", bus.empty, 1);
      chk("rst_level", bus.level, 0);
      chk("rst_send", bus.send, 0);
      chk("rst_msg", bus.Msg, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_full", bus.full, 0);
      chk("rst_ovf", bus.overflow, 0);
    end
    bus.enable = 1'b0; bus.wr_en = 1'b0; bus.wr_data = '0;
    bus.ovf_clr = 1'b0; bus.bit_tick = 1'b0;
    rst = 1'b1;
    bus.enable = 1'b1;
    repeat (2) begin
      do_tick();
      chk("idle_send", bus.send, 0);
      chk("idle_busy", bus.busy, 0);
      chk("idle_empty", bus.empty, 1);
    end

    // Single frame.
    bus.wr_en = 1'b1; bus.wr_data = 5'b10110; sb.push_back(5'b10110);
    step();
    bus.wr_en = 1'b0;
    chk("sf_send_e1", bus.send, 0);
    chk("sf_empty_e1", bus.empty, 0);
    chk("sf_level_e1", bus.level, 1);
    step();
    chk("sf_send_e2", bus.send, 1);
    chk("sf_busy_e2", bus.busy, 1);
    chk("sf_msg_e2", bus.Msg, 5'b10110);
    chk("sf_empty_e2", bus.empty, 1);
    for (int t = 1; t <= MB + GB; t++) begin
      do_tick();
      chk("sf_send", bus.send, 0);
      chk("sf_busy", bus.busy, (t < MB + GB) ? 1 : 0);
      chk("sf_msg", bus.Msg, 5'b10110);
    end

    // Tick coinciding with the IDLE->SEND edge must not release send.
    write_msg(5'h15);
    bus.bit_tick = 1'b1;
    step();
    bus.bit_tick = 1'b0;
    chk("st_send_start", bus.send, 1);
    step();
    chk("st_send_held", bus.send, 1);
    for (int t = 1; t <= MB + GB; t++) begin
      do_tick();
      chk("st_send", bus.send, 0);
      chk("st_busy", bus.busy, (t < MB + GB) ? 1 : 0);
    end

    // Back-to-back frames.
    write_msg(5'h03);
    write_msg(5'h1C);
    write_msg(5'h0F);
    chk("bb_level", bus.level, 2);
    chk("bb_send0", bus.send, 1);
    for (int t = 1; t <= 3 * (MB + GB); t++) begin
      do_tick();
      exp_m = (t < 7) ? 5'h03 : (t < 14) ? 5'h1C : 5'h0F;
      chk("bb_msg", bus.Msg, exp_m);
      chk("bb_busy", bus.busy, (t < 21) ? 1 : 0);
      chk("bb_send", bus.send, (t == 7 || t == 14) ? 1 : 0);
      if (t == 14) chk("bb_empty", bus.empty, 1);
    end

    // Overflow table, no frames started.
    bus.enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vt[i].wr_en = 1'b1; vt[i].data = MB'(i + 3); vt[i].clr = 1'b0;
      vt[i].exp_full = (i == 7); vt[i].exp_level = LW'(i + 1); vt[i].exp_ovf = 1'b0;
    end
    vt[8]  = '{1'b1, 5'h1F, 1'b0, 1'b1, LW'(8), 1'b1};
    vt[9]  = '{1'b0, 5'h00, 1'b1, 1'b1, LW'(8), 1'b0};
    vt[10] = '{1'b1, 5'h1E, 1'b1, 1'b1, LW'(8), 1'b1};
    vt[11] = '{1'b0, 5'h00, 1'b1, 1'b1, LW'(8), 1'b0};
    vt[12] = '{1'b0, 5'h00, 1'b0, 1'b1, LW'(8), 1'b0};
    prev_full = 1'b0;
    for (int i = 0; i < 13; i++) begin
      bus.wr_en   = vt[i].wr_en;
      bus.wr_data = vt[i].data;
      bus.ovf_clr = vt[i].clr;
      if (vt[i].wr_en && !prev_full) sb.push_back(vt[i].data);
      step();
      bus.wr_en   = 1'b0;
      bus.ovf_clr = 1'b0;
      chk("tv_full", bus.full, vt[i].exp_full);
      chk("tv_level", bus.level, vt[i].exp_level);
      chk("tv_ovf", bus.overflow, vt[i].exp_ovf);
      prev_full = vt[i].exp_full;
    end

    // Write while full, with a pop in the same cycle: still dropped.
    bus.enable = 1'b1;
    bus.wr_en = 1'b1; bus.wr_data = 5'h1D;
    step();
    bus.wr_en = 1'b0;
    chk("fp_level", bus.level, 7);
    chk("fp_full", bus.full, 0);
    chk("fp_ovf", bus.overflow, 1);
    chk("fp_send", bus.send, 1);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    chk("fp_ovf_clr", bus.overflow, 0);
    repeat (8 * (MB + GB)) do_tick();
    chk("drain_busy", bus.busy, 0);
    chk("drain_empty", bus.empty, 1);
    chk("drain_sb", sb.size(), 0);

    // Enable gating mid-frame.
    write_msg(5'h11);
    write_msg(5'h12);
    write_msg(5'h13);
    chk("eg_level0", bus.level, 2);
    do_tick();
    do_tick();
    bus.enable = 1'b0;
    for (int t = 3; t <= MB + GB; t++) do_tick();
    chk("eg_busy", bus.busy, 0);
    chk("eg_send", bus.send, 0);
    chk("eg_level", bus.level, 2);
    repeat (5) step();
    chk("eg_idle_send", bus.send, 0);
    chk("eg_idle_busy", bus.busy, 0);
    bus.enable = 1'b1;
    step();
    chk("eg_re_send", bus.send, 1);
    chk("eg_re_busy", bus.busy, 1);
    chk("eg_re_msg", bus.Msg, 5'h12);
    chk("eg_re_level", bus.level, 1);
    repeat (2 * (MB + GB)) do_tick();
    chk("eg_end_busy", bus.busy, 0);
    chk("eg_end_empty", bus.empty, 1);

    // Reset mid-frame.
    write_msg(5'h05);
    write_msg(5'h06);
    write_msg(5'h07);
    write_msg(5'h08);
    chk("rm_level", bus.level, 3);
    do_tick();
    do_tick();
    chk("rm_busy_pre", bus.busy, 1);
    #3;
    rst = 1'b0;
    #1;
    chk("rm_send", bus.send, 0);
    chk("rm_busy", bus.busy, 0);
    chk("rm_level0", bus.level, 0);
    chk("rm_empty", bus.empty, 1);
    chk("rm_msg", bus.Msg, 0);
    sb.delete();
    step();
    step();
    rst = 1'b1;
    repeat (2) begin
      do_tick();
      chk("rm_no_send", bus.send, 0);
      chk("rm_no_busy", bus.busy, 0);
    end
    write_msg(5'h19);
    step();
    chk("rm_new_send", bus.send, 1);
    chk("rm_new_msg", bus.Msg, 5'h19);
    repeat (MB + GB) do_tick();
    chk("rm_new_done", bus.busy, 0);
    chk("final_sb", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
